// File: rtl/alu_pkg.sv
// alu_pkg: op encoding and condition-code bundle shared by the Y86
// execute-stage ALU and its users.
package alu_pkg;

   // Operation encoding on in_op.
   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_XOR = 2'b11;

   // Y86 condition codes produced with every result.
   typedef struct packed {
      logic zf;
      logic sf;
      logic of;
   } alu_flags_t;

   // ADD and SUB use the sliced carry chain; AND and XOR do not.
   function automatic logic op_is_arith(input logic [1:0] op);
      return (op == ALU_ADD) || (op == ALU_SUB);
   endfunction

endpackage

// File: rtl/addsub_slice.sv
// addsub_slice: CHUNK-bit ripple adder slice with carry-in and carry-out.
// Subtraction is handled by the caller, which supplies ~b and ci = 1.
module addsub_slice #(
   parameter int CHUNK = 16
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             ci,
   output logic [CHUNK-1:0] sum,
   output logic             co
);

   // Widen by one bit so the carry-out falls out of the same addition.
   assign {co, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};

endmodule

// File: rtl/alu_addsub_pipe.sv
// alu_addsub_pipe: pipelined WIDTH-bit ADD/SUB/AND/XOR unit for the Y86
// execute stage. The carry chain is cut into CHUNK-bit slices, one slice
// per stage, so a result leaves NSTG = WIDTH/CHUNK cycles after acceptance.
// All stages advance together (adv); a stalled output freezes the pipe.
// WIDTH must be a multiple of CHUNK and give at least two stages.
//
// Optional build macro ALU_ADDSUB_CF_EN adds the out_cf carry/borrow flag.
module alu_addsub_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_res,
   output logic             out_zf,
   output logic             out_sf,
   output logic             out_of
`ifdef ALU_ADDSUB_CF_EN
   ,
   output logic             out_cf
`endif
);

   localparam int NSTG = WIDTH / CHUNK;
   localparam int LAST = NSTG - 1;

   // Everything an op carries down the pipe. 'bx' is B already inverted
   // for SUB; 'res' fills in one slice per stage (or is complete from
   // stage 0 for AND/XOR); 'cy' is the carry into the next slice.
   typedef struct packed {
      logic [1:0]       op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] bx;
      logic [WIDTH-1:0] res;
      logic             cy;
   } stage_t;

   logic             adv;
   stage_t           st_in  [NSTG];
   stage_t           st_out [NSTG];
   stage_t           st_q   [NSTG-1];
   logic             vld_q  [NSTG-1];

   logic [CHUNK-1:0] sl_a   [NSTG];
   logic [CHUNK-1:0] sl_b   [NSTG];
   logic [CHUNK-1:0] sl_sum [NSTG];
   logic             sl_ci  [NSTG];
   logic             sl_co  [NSTG];

   alu_flags_t       flags_d;
   alu_flags_t       flags_q;
   logic [WIDTH-1:0] res_q;
   logic             out_valid_q;

`ifdef ALU_ADDSUB_CF_EN
   logic             cf_d;
   logic             cf_q;
`endif

   // Single global enable: the pipe moves whenever the output slot is
   // empty or being drained this cycle.
   assign adv      = !out_valid_q || out_ready;
   assign in_ready = adv;

   // Build each stage's input word and pick out the slice it adds.
   always_comb begin
      // NOTE: every variable written here gets a full default before any
      // conditional code, so no path can leave it unassigned (no latch).
      st_in[0]    = '0;
      st_in[0].op = in_op;
      st_in[0].a  = in_a;
      st_in[0].bx = (in_op == ALU_SUB) ? ~in_b : in_b;
      st_in[0].cy = (in_op == ALU_SUB);
      // Logic ops finish here for the whole word and then just ride along.
      case (in_op)
         ALU_AND: st_in[0].res = in_a & in_b;
         ALU_XOR: st_in[0].res = in_a ^ in_b;
         default: st_in[0].res = '0;
      endcase

      for (int k = 1; k < NSTG; k++) begin
         st_in[k] = st_q[k-1];
      end

      for (int k = 0; k < NSTG; k++) begin
         sl_a[k]  = st_in[k].a[k*CHUNK +: CHUNK];
         sl_b[k]  = st_in[k].bx[k*CHUNK +: CHUNK];
         sl_ci[k] = st_in[k].cy;
      end
   end

   // One adder slice per pipeline stage.
   for (genvar k = 0; k < NSTG; k++) begin : g_slice
      addsub_slice #(
         .CHUNK (CHUNK)
      ) u_slice (
         .a   (sl_a[k]),
         .b   (sl_b[k]),
         .ci  (sl_ci[k]),
         .sum (sl_sum[k]),
         .co  (sl_co[k])
      );
   end

   // Merge each slice sum into its stage's result; logic ops pass through.
   always_comb begin
      for (int k = 0; k < NSTG; k++) begin
         st_out[k] = st_in[k];
         if (op_is_arith(st_in[k].op)) begin
            st_out[k].res[k*CHUNK +: CHUNK] = sl_sum[k];
            st_out[k].cy                    = sl_co[k];
         end
      end
   end

   // Condition codes from the completed result of the final stage.
   // Because bx already holds ~b for SUB, "a and bx share a sign" is the
   // ADD overflow test and the SUB overflow test at the same time.
   always_comb begin
      flags_d.zf = (st_out[LAST].res == '0);
      flags_d.sf = st_out[LAST].res[WIDTH-1];
      flags_d.of = op_is_arith(st_out[LAST].op)
                   && (st_out[LAST].a[WIDTH-1] == st_out[LAST].bx[WIDTH-1])
                   && (st_out[LAST].res[WIDTH-1] != st_out[LAST].a[WIDTH-1]);
   end

`ifdef ALU_ADDSUB_CF_EN
   // Carry for ADD, borrow (inverted carry) for SUB, zero for logic ops.
   always_comb begin
      case (st_out[LAST].op)
         ALU_ADD: cf_d = st_out[LAST].cy;
         ALU_SUB: cf_d = !st_out[LAST].cy;
         default: cf_d = 1'b0;
      endcase
   end
`endif

   // Stage registers and output register: advance together on adv,
   // flush wins over stall and drops every in-flight op.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the data registers are cleared along with the valid bits
         // so the outputs read zero straight out of reset.
         for (int k = 0; k < NSTG-1; k++) begin
            vld_q[k] <= 1'b0;
            st_q[k]  <= '0;
         end
         out_valid_q <= 1'b0;
         res_q       <= '0;
         flags_q     <= '0;
`ifdef ALU_ADDSUB_CF_EN
         cf_q        <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments, so each stage captures its
         // neighbour's pre-edge value and the shift happens in one step.
         if (adv) begin
            vld_q[0] <= in_valid;
            for (int k = 1; k < NSTG-1; k++) begin
               vld_q[k] <= vld_q[k-1];
            end
            for (int k = 0; k < NSTG-1; k++) begin
               st_q[k] <= st_out[k];
            end
            out_valid_q <= vld_q[NSTG-2];
            res_q       <= st_out[LAST].res;
            flags_q     <= flags_d;
`ifdef ALU_ADDSUB_CF_EN
            cf_q        <= cf_d;
`endif
         end
         if (flush) begin
            for (int k = 0; k < NSTG-1; k++) begin
               vld_q[k] <= 1'b0;
            end
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_res   = res_q;
   assign out_zf    = flags_q.zf;
   assign out_sf    = flags_q.sf;
   assign out_of    = flags_q.of;
`ifdef ALU_ADDSUB_CF_EN
   assign out_cf    = cf_q;
`endif

endmodule

// File: tb/tb_alu_addsub_pipe.sv
// tb_alu_addsub_pipe: table of hand-computed vectors streamed through a
// scoreboard queue, plus directed stall, flush and reset sequences and a
// short randomized run under random backpressure.
module tb_alu_addsub_pipe;
   import alu_pkg::*;

   localparam int W    = 64;
   localparam int C    = 16;
   localparam int NSTG = W / C;
`ifdef ALU_ADDSUB_CF_EN
   localparam bit CF_EN = 1'b1;
`else
   localparam bit CF_EN = 1'b0;
`endif

   typedef struct packed {
      logic [W-1:0] res;
      logic         zf;
      logic         sf;
      logic         of;
      logic         cf;
   } exp_t;

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      exp_t         e;
   } vec_t;

   logic         clk;
   logic         rst_n;
   logic         flush;
   logic         in_valid;
   logic         in_ready;
   logic [1:0]   in_op;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_res;
   logic         out_zf;
   logic         out_sf;
   logic         out_of;
   logic         cf_w;

   int           checks   = 0;
   int           failures = 0;
   exp_t         sb[$];
   bit           bp_en    = 1'b0;
   vec_t         vecs[14];

   alu_addsub_pipe #(
      .WIDTH (W),
      .CHUNK (C)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res),
      .out_zf    (out_zf),
      .out_sf    (out_sf),
      .out_of    (out_of)
`ifdef ALU_ADDSUB_CF_EN
      ,
      .out_cf    (cf_w)
`endif
   );

`ifndef ALU_ADDSUB_CF_EN
   assign cf_w = 1'b0;
`endif

   logic [67:0] act;
   assign act = {out_res, out_zf, out_sf, out_of, cf_w};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [67:0] got, input logic [67:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   function automatic logic [67:0] pk(input exp_t e);
      return {e.res, e.zf, e.sf, e.of, (CF_EN ? e.cf : 1'b0)};
   endfunction

   function automatic vec_t mk(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] res, input logic zf, input logic sf,
                               input logic of, input logic cf);
      vec_t v;
      v.op = op; v.a = a; v.b = b;
      v.e  = '{res: res, zf: zf, sf: sf, of: of, cf: cf};
      return v;
   endfunction

   // Reference model for the random phase, written from the arithmetic
   // definitions (wide add for carry, unsigned compare for borrow).
   function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t     e;
      logic [W:0] s;
      e = '0;
      case (op)
         ALU_ADD: begin
            s     = {1'b0, a} + {1'b0, b};
            e.res = s[W-1:0];
            e.cf  = s[W];
            e.of  = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
         end
         ALU_SUB: begin
            e.res = a - b;
            e.cf  = (a < b);
            e.of  = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
         end
         ALU_AND: e.res = a & b;
         default: e.res = a ^ b;
      endcase
      e.zf = (e.res == '0);
      e.sf = e.res[W-1];
      return e;
   endfunction

   // Offer one op; the expectation is queued at the cycle it is accepted.
   task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
      bit acc = 1'b0;
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
      for (int i = 0; i < 200 && !acc; i++) begin
         @(negedge clk);
         if (in_ready) begin
            acc = 1'b1;
            sb.push_back(e);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("accept", acc, 1);
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && sb.size() > 0; i++) @(negedge clk);
      @(posedge clk); #1;
      check("drain_empty", sb.size(), 0);
   endtask

   task automatic measure_latency();
      int n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("latency", n, NSTG);
   endtask

   // Scoreboard monitor: every output handshake must match the oldest
   // outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            check("output_expected", (sb.size() > 0), 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check("result", act, pk(e));
            end
         end
      end
   end

   // Random backpressure on the consumer side.
   initial begin
      forever begin
         @(posedge clk); #1;
         if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      logic [67:0] snap;
      bit          rose;
      logic [1:0]  rop;
      logic [W-1:0] ra, rb;

      vecs[0]  = mk(ALU_SUB, 64'd2811, 64'd1012, 64'd1799, 0, 0, 0, 0);
      vecs[1]  = mk(ALU_SUB, -64'sd1243, 64'd1234, -64'sd2477, 0, 1, 0, 0);
      vecs[2]  = mk(ALU_SUB, 64'd5, 64'd5, 64'd0, 1, 0, 0, 0);
      vecs[3]  = mk(ALU_SUB, 64'h8000_0000_0000_0001, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 1, 0);
      vecs[4]  = mk(ALU_SUB, 64'd9223372036854775800, -64'sd10, 64'h8000_0000_0000_0002, 0, 1, 1, 1);
      vecs[5]  = mk(ALU_ADD, 64'h0000_0000_0000_FFFF, 64'd1, 64'h0000_0000_0001_0000, 0, 0, 0, 0);
      vecs[6]  = mk(ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1, 0, 0, 1);
      vecs[7]  = mk(ALU_AND, 64'h0000_0000_0000_F0F0, 64'h0000_0000_0000_FF00, 64'h0000_0000_0000_F000, 0, 0, 0, 0);
      vecs[8]  = mk(ALU_XOR, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'd0, 1, 0, 0, 0);
      vecs[9]  = mk(ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 0, 1, 1, 0);
      vecs[10] = mk(ALU_ADD, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 1, 0, 1, 1);
      vecs[11] = mk(ALU_XOR, 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_0F0F_F0F0_0F0F, 0, 1, 0, 0);
      vecs[12] = mk(ALU_ADD, 64'h0000_FFFF_FFFF_FFFF, 64'd1, 64'h0001_0000_0000_0000, 0, 0, 0, 0);
      vecs[13] = mk(ALU_SUB, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0, 1);

      rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_op = ALU_ADD; in_a = '0; in_b = '0;

      // Reset state.
      #2 rst_n = 1'b0;
      #1;
      check("reset_out_valid", out_valid, 0);
      check("reset_outputs", act, '0);
      check("reset_in_ready", in_ready, 1);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Single op: exact latency and result.
      send(vecs[0].op, vecs[0].a, vecs[0].b, vecs[0].e);
      measure_latency();
      drain();

      // Whole table back-to-back.
      foreach (vecs[i]) send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e);
      drain();

      // Stall: consumer holds off while two ops are in flight.
      out_ready = 1'b0;
      send(vecs[5].op, vecs[5].a, vecs[5].b, vecs[5].e);
      send(vecs[6].op, vecs[6].a, vecs[6].b, vecs[6].e);
      for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
      check("stall_out_valid", out_valid, 1);
      snap = act;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_in_ready", in_ready, 0);
         check("stall_out_valid_hold", out_valid, 1);
         check("stall_outputs_hold", act, snap);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      drain();

      // Flush with three ops in flight; an op offered during flush is dropped.
      send(ALU_ADD, 64'd10, 64'd20, model(ALU_ADD, 64'd10, 64'd20));
      send(ALU_SUB, 64'd10, 64'd20, model(ALU_SUB, 64'd10, 64'd20));
      send(ALU_XOR, 64'd10, 64'd20, model(ALU_XOR, 64'd10, 64'd20));
      flush = 1'b1; in_valid = 1'b1; in_op = ALU_ADD; in_a = 64'd7; in_b = 64'd8;
      sb.delete();
      #1 check("flush_in_ready", in_ready, 1);
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      rose = 1'b0;
      repeat (NSTG + 3) begin
         @(negedge clk);
         if (out_valid) rose = 1'b1;
      end
      check("flush_no_output", rose, 0);
      @(posedge clk); #1;

      // Random ops under random backpressure.
      bp_en = 1'b1;
      for (int i = 0; i < 40; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = {$urandom, $urandom};
         rb  = (i % 7 == 3) ? ra : {$urandom, $urandom};
         send(rop, ra, rb, model(rop, ra, rb));
      end
      bp_en = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      drain();

      // Reset mid-stream with a result waiting on the output.
      out_ready = 1'b0;
      send(ALU_ADD, 64'd100, 64'd23, model(ALU_ADD, 64'd100, 64'd23));
      send(ALU_SUB, 64'd900, 64'd1, model(ALU_SUB, 64'd900, 64'd1));
      for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
      check("pre_reset_valid", out_valid, 1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      sb.delete();
      #1;
      check("midreset_out_valid", out_valid, 0);
      check("midreset_outputs", act, '0);
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      rose = 1'b0;
      repeat (NSTG + 2) begin
         @(negedge clk);
         if (out_valid) rose = 1'b1;
      end
      check("after_reset_no_output", rose, 0);
      @(posedge clk); #1;
      send(vecs[3].op, vecs[3].a, vecs[3].b, vecs[3].e);
      measure_latency();
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
